// File: rtl/led_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment datapath among four clients.
// Owners keep the display for at least HOLD cycles and may lock it indefinitely.
module led_display_arbiter #(
  parameter int unsigned HOLD = 40,
  parameter int unsigned DW   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [3:0]   lock,
  input  logic [255:0] req_values,
  output logic [3:0]   grant,
  output logic [1:0]   owner,
  output logic [63:0]  disp_values,
  output logic         disp_blank
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_grant, w_grant_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [63:0]   r_disp_values, w_disp_values_nxt;
  logic          r_disp_blank, w_disp_blank_nxt;

  logic [2:0]    w_idle_pick;
  logic [2:0]    w_pre_pick;
  logic          w_hold_done;
  logic [63:0]   w_owner_word;

  // Returns {found, index}: first set bit of mask scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int n = 3; n >= 0; n--) begin
      idx = start + 2'(n);
      if (mask[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_idle_pick  = rr_pick(req, r_ptr);
  assign w_pre_pick   = rr_pick(req & ~(4'b0001 << r_owner), r_ptr);
  assign w_hold_done  = (r_dwell >= DW'(HOLD));
  assign w_owner_word = req_values[{r_owner, 6'd0} +: 64];

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_owner_nxt       = r_owner;
    w_ptr_nxt         = r_ptr;
    w_dwell_nxt       = r_dwell;
    w_disp_values_nxt = '1;
    w_disp_blank_nxt  = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_dwell_nxt = '0;
        if (w_idle_pick[2]) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = 4'b0001 << w_idle_pick[1:0];
          w_owner_nxt = w_idle_pick[1:0];
          w_ptr_nxt   = w_idle_pick[1:0] + 2'd1;
        end
      end
      S_OWN: begin
        if (!req[r_owner]) begin
          // Release always passes through one dark IDLE cycle.
          w_state_nxt = S_IDLE;
          w_grant_nxt = 4'b0000;
          w_dwell_nxt = '0;
        end else begin
          w_disp_values_nxt = w_owner_word;
          w_disp_blank_nxt  = 1'b0;
          if (!lock[r_owner] && w_hold_done && w_pre_pick[2]) begin
            w_grant_nxt = 4'b0001 << w_pre_pick[1:0];
            w_owner_nxt = w_pre_pick[1:0];
            w_ptr_nxt   = w_pre_pick[1:0] + 2'd1;
            w_dwell_nxt = '0;
          end else if (!w_hold_done) begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_dwell_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= 4'b0000;
      r_owner       <= 2'd0;
      r_ptr         <= 2'd0;
      r_dwell       <= '0;
      r_disp_values <= '1;
      r_disp_blank  <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_ptr         <= w_ptr_nxt;
      r_dwell       <= w_dwell_nxt;
      r_disp_values <= w_disp_values_nxt;
      r_disp_blank  <= w_disp_blank_nxt;
    end
  end

  assign grant       = r_grant;
  assign owner       = r_owner;
  assign disp_values = r_disp_values;
  assign disp_blank  = r_disp_blank;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter: two instances (HOLD=40 and HOLD=4) on shared inputs,
// expectations queued per step and popped after each clock edge.
module tb_led_display_arbiter;

  localparam logic [63:0] V0   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] V1   = 64'h0011_2233_4455_6677;
  localparam logic [63:0] V2   = 64'h0100_0200_0006_0109;
  localparam logic [63:0] V3   = 64'hCAFE_F00D_DEAD_BEEF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [255:0] req_values;
  logic [3:0]   grant,  grant4;
  logic [1:0]   owner,  owner4;
  logic [63:0]  dvals,  dvals4;
  logic         dblank, dblank4;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          sel4;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [63:0] vals;
    logic        blank;
    bit          chkv;
  } exp_t;

  exp_t sb[$];

  led_display_arbiter #(.HOLD(40), .DW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_values(req_values),
    .grant(grant), .owner(owner), .disp_values(dvals), .disp_blank(dblank)
  );

  led_display_arbiter #(.HOLD(4), .DW(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_values(req_values),
    .grant(grant4), .owner(owner4), .disp_values(dvals4), .disp_blank(dblank4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: test did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input bit sel4, input logic [3:0] g, input logic [1:0] o,
                      input logic [63:0] v, input logic b, input bit chkv);
    exp_t e;
    e.tag = tag; e.sel4 = sel4; e.grant = g; e.owner = o; e.vals = v; e.blank = b; e.chkv = chkv;
    sb.push_back(e);
  endtask

  task automatic check_top();
    exp_t        e;
    logic [3:0]  og;
    logic [1:0]  oo;
    logic [63:0] ov;
    logic        ob;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e  = sb.pop_front();
    og = e.sel4 ? grant4  : grant;
    oo = e.sel4 ? owner4  : owner;
    ov = e.sel4 ? dvals4  : dvals;
    ob = e.sel4 ? dblank4 : dblank;
    n_assert++;
    assert (og === e.grant) else begin
      n_fail++;
      $error("FAIL %s grant observed=%b expected=%b", e.tag, og, e.grant);
    end
    if (e.grant != 4'b0000) begin
      n_assert++;
      assert (oo === e.owner) else begin
        n_fail++;
        $error("FAIL %s owner observed=%0d expected=%0d", e.tag, oo, e.owner);
      end
    end
    n_assert++;
    assert (ob === e.blank) else begin
      n_fail++;
      $error("FAIL %s disp_blank observed=%b expected=%b", e.tag, ob, e.blank);
    end
    if (e.chkv) begin
      n_assert++;
      assert (ov === e.vals) else begin
        n_fail++;
        $error("FAIL %s disp_values observed=%h expected=%h", e.tag, ov, e.vals);
      end
    end
  endtask

  task automatic step(input string tag, input bit sel4, input logic [3:0] g, input logic [1:0] o,
                      input logic [63:0] v, input logic b, input bit chkv);
    push(tag, sel4, g, o, v, b, chkv);
    tick();
    check_top();
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    lock  = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    req        = 4'b0000;
    lock       = 4'b0000;
    req_values = {V3, V2, V1, V0};
    #2;
    rst_n = 1'b0;
    tick();
    push("reset", 1'b0, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);
    check_top();
    push("reset4", 1'b1, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);
    check_top();
    n_assert++;
    assert (owner === 2'd0) else begin
      n_fail++;
      $error("FAIL reset_owner observed=%0d expected=0", owner);
    end
    rst_n = 1'b1;

    // Single client
    req = 4'b0100;
    step("single_grant", 1'b0, 4'b0100, 2'd2, ONES, 1'b1, 1'b1);
    step("single_data",  1'b0, 4'b0100, 2'd2, V2,   1'b0, 1'b1);
    req = 4'b0000;
    step("single_rel",   1'b0, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);
    step("single_idle",  1'b0, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);

    // Simultaneous requests, release with a waiter
    do_reset();
    req = 4'b1010;
    step("simul_grant1", 1'b0, 4'b0010, 2'd1, ONES, 1'b1, 1'b1);
    step("simul_data1",  1'b0, 4'b0010, 2'd1, V1,   1'b0, 1'b1);
    req = 4'b1000;
    step("simul_gap",    1'b0, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);
    step("simul_grant3", 1'b0, 4'b1000, 2'd3, ONES, 1'b1, 1'b1);
    step("simul_data3",  1'b0, 4'b1000, 2'd3, V3,   1'b0, 1'b1);
    req = 4'b0000;
    step("simul_rel3",   1'b0, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);

    // Preemption after HOLD=40
    do_reset();
    req = 4'b0001;
    step("pre_grant0", 1'b0, 4'b0001, 2'd0, ONES, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i == 5) req = 4'b0101;
      step("pre_hold", 1'b0, 4'b0001, 2'd0, V0, 1'b0, 1'b1);
    end
    step("pre_switch", 1'b0, 4'b0100, 2'd2, V0, 1'b0, 1'b1);
    step("pre_newdata", 1'b0, 4'b0100, 2'd2, V2, 1'b0, 1'b1);

    // Lock holds the display well past HOLD
    do_reset();
    req  = 4'b0001;
    lock = 4'b0001;
    step("lock_grant0", 1'b0, 4'b0001, 2'd0, ONES, 1'b1, 1'b1);
    req = 4'b1001;
    for (int i = 0; i < 200; i++) begin
      step("lock_hold", 1'b0, 4'b0001, 2'd0, V0, 1'b0, 1'b1);
    end
    lock = 4'b0000;
    step("lock_drop", 1'b0, 4'b1000, 2'd3, V0, 1'b0, 1'b1);
    step("lock_data3", 1'b0, 4'b1000, 2'd3, V3, 1'b0, 1'b1);

    // Fairness with HOLD=4: each client keeps the display exactly 5 cycles
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 25; n++) begin
      step("fair_seq", 1'b1, 4'b0001 << ((n / 5) % 4), 2'((n / 5) % 4), ONES, (n == 0), 1'b0);
    end
    req = 4'b0000;
    step("fair_rel", 1'b1, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);

    // Asynchronous reset while client 2 owns
    do_reset();
    req = 4'b0100;
    step("arst_grant2", 1'b0, 4'b0100, 2'd2, ONES, 1'b1, 1'b1);
    step("arst_data2",  1'b0, 4'b0100, 2'd2, V2,   1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_now", 1'b0, 4'b0000, 2'd0, ONES, 1'b1, 1'b1);
    check_top();
    n_assert++;
    assert (owner === 2'd0) else begin
      n_fail++;
      $error("FAIL arst_owner observed=%0d expected=0", owner);
    end
    req = 4'b1111;
    tick();
    rst_n = 1'b1;
    step("arst_regrant0", 1'b0, 4'b0001, 2'd0, ONES, 1'b1, 1'b1);
    step("arst_data0",    1'b0, 4'b0001, 2'd0, V0,   1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
Shares the single 8-digit seven-segment display datapath (led_display, 64-bit values word at 8 bits per digit) between 4 requesting clients, e.g. countdown, student-ID banner, stopwatch and debug view. Round-robin arbitration with a minimum dwell time before preemption and a per-client lock. Output drives led_display.values directly. A separate blank flag forces the display dark while no client owns it.

Parameters:
HOLD, 40, minimum cycles a granted client keeps the display before a waiting client may preempt it; must be >= 1
DW, 32, width of the dwell counter; HOLD must be < 2^DW

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  req[i]=1: client i wants the display
lock  input  4  lock[i]=1: client i, if owner, must not be preempted
req_values  input  256  client i display word at [64*i +: 64], same digit layout as led_display.values
grant  output  4  one-hot registered grant, all zero when idle
owner  output  2  index of current owner, valid only when grant != 0
disp_values  output  64  registered word for led_display.values
disp_blank  output  1  1 = display must be dark (downstream gates led_en / segments)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, grant=0, owner=0, rr pointer ptr=0, dwell=0, disp_values=64'hFFFF_FFFF_FFFF_FFFF, disp_blank=1. Reset release mid-ownership discards the owner. No grant until req is resampled after release.
- Round-robin search: starting from index ptr, scan ptr, ptr+1, ... mod 4. The first index with req=1 wins. After any grant to index k, ptr <= (k+1) mod 4.
- IDLE: grant=0, disp_blank=1, disp_values holds all-ones. If req != 0 at edge N, then at N+1: state=OWN, grant=one-hot(winner), owner=winner, dwell=0.
- OWN, owner k, evaluated each edge in this order:
  1. Release: req[k]=0 -> next edge state=IDLE, grant=0, dwell=0. This always takes one IDLE cycle, even if others are waiting.
  2. Preempt: req[k]=1, lock[k]=0, dwell >= HOLD, and another req[j]=1 with j != k -> next edge grant moves to the round-robin winner among j != k (search from ptr, skipping k), dwell=0. No IDLE gap.
  3. Otherwise: keep grant. dwell increments, saturating at HOLD.
- lock[k] only matters while k owns the display. Locking while not owner has no effect. Dropping lock after dwell >= HOLD allows preemption on the next evaluation edge.
- Datapath: in OWN, disp_values <= req_values[64*owner +: 64] every edge, i.e. one-cycle latency from the owner's word to the output. disp_blank <= 0 on the edge after grant first asserts. So the first valid disp_values and disp_blank=0 appear one cycle after grant.
- On release, disp_blank <= 1 and disp_values <= all-ones on the same edge that grant clears.
- On a preempt switch, disp_values follows the new owner one cycle after grant changes. During that cycle it still shows the old owner's last word, and disp_blank stays 0.
- grant is always zero or one-hot, and owner always matches grant when grant != 0.
- req changes by a non-owner never disturb the current owner before HOLD.

Test Plan:
- Single client: reset, then req=4'b0100 at edge 0, req_values[191:128]=64'h0100_0200_0006_0109 -> grant=4'b0100, owner=2 at edge 1; disp_values=64'h0100_0200_0006_0109 and disp_blank=0 at edge 2.
- Simultaneous: after reset, req=4'b1010 -> grant 4'b0010 first. Client 1 releases -> one IDLE cycle (grant=0, disp_blank=1) -> grant 4'b1000.
- Preempt with HOLD=40: client 0 owns, client 2 raises req at dwell 5 -> grant stays 4'b0001 until dwell=40, then switches to 4'b0100 on the next edge with no IDLE cycle.
- Lock: client 0 owns with lock[0]=1, client 3 requesting for 200 cycles -> grant stays 4'b0001. Drop lock[0] -> grant=4'b1000 on the next edge.
- Fairness: all four req held high, HOLD=4 -> grant sequence 0,1,2,3,0, each held exactly 5 cycles (dwell 0..4).
- Reset mid-operation: assert rst_n=0 while client 2 owns -> grant=0, disp_blank=1, disp_values=all-ones immediately, asynchronously. After release with req=4'b1111 -> client 0 is granted (ptr reset to 0).
